// File: rtl/itch_pkg.sv
// Shared ITCH arbiter definitions: message geometry, the Add Order type code
// and the arbiter state encoding used by itch_feed_arb.
package itch_pkg;

    localparam int         ITCH_MSG_LEN       = 15;
    localparam logic [7:0] ITCH_MSG_ADD_ORDER = 8'h41;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    // Convenience for downstream parsers; the arbiter never inspects bytes.
    function automatic logic is_add_order(input logic [7:0] b);
        return b == ITCH_MSG_ADD_ORDER;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// position after the pointer, wrapping, and returns the first requester.
module rr_pick #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_cand;

    // Priority scan from (ptr+1) mod N; the first hit wins.
    always_comb begin
        // NOTE: every output and temporary gets a default before the loop, so no path can infer a latch.
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int off = 1; off <= N; off++) begin
            w_cand = IW'((int'(i_ptr) + off) % N);
            if (!o_found && i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/itch_feed_arb.sv
// ITCH feed arbiter: merges NUM_FEEDS byte streams of fixed-length messages
// onto one parser stream, whole messages at a time, round-robin between feeds.
// Optional per-feed completed-message counters are built when the macro
// ITCH_ARB_STATS_EN is defined; otherwise msg_count is tied to zero.
module itch_feed_arb
    import itch_pkg::*;
#(
    parameter  int NUM_FEEDS = 2,
    parameter  int MSG_LEN   = ITCH_MSG_LEN,
    localparam int GW        = $clog2(NUM_FEEDS),
    localparam int CW        = $clog2(MSG_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_FEEDS-1:0] s_axis_tdata,
    input  logic [NUM_FEEDS-1:0]   s_axis_tvalid,
    output logic [NUM_FEEDS-1:0]   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [GW-1:0]          grant_id,
    output logic                   grant_active,
    output logic [16*NUM_FEEDS-1:0] msg_count
);

    arb_state_t    r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_rr_ptr;
    logic [CW-1:0] r_cnt;

    logic [GW-1:0] w_pick;
    logic          w_found;
    logic          w_hs;
    logic          w_last_beat;

    rr_pick #(
        .N (NUM_FEEDS)
    ) u_rr_pick (
        .i_req   (s_axis_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign grant_active  = (r_state == PASS);
    assign grant_id      = r_grant;
    assign m_axis_tdata  = s_axis_tdata[8*r_grant +: 8];
    assign m_axis_tvalid = grant_active & s_axis_tvalid[r_grant];
    assign w_hs          = m_axis_tvalid & m_axis_tready;
    assign w_last_beat   = (r_cnt == CW'(MSG_LEN - 1));
    assign m_axis_tlast  = grant_active & w_last_beat;

    // Only the granted feed sees parser backpressure; everyone else stalls.
    always_comb begin
        s_axis_tready = '0;
        if (grant_active) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    // Arbiter FSM: pick a feed in IDLE, pass one whole message in PASS.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so each register sees the pre-edge values of the others.
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= GW'(NUM_FEEDS - 1);
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= PASS;
                    end
                end
                PASS: begin
                    if (w_hs) begin
                        if (w_last_beat) begin
                            r_cnt    <= '0;
                            r_rr_ptr <= r_grant;
                            r_state  <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ITCH_ARB_STATS_EN
    logic [15:0] r_msg_count [NUM_FEEDS];

    // Count completed messages per feed; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        // NOTE: these counters are a handful of flops, not a RAM, so they are cleared on reset.
        if (rst) begin
            for (int k = 0; k < NUM_FEEDS; k++) begin
                r_msg_count[k] <= '0;
            end
        end else if (w_hs && w_last_beat) begin
            r_msg_count[r_grant] <= r_msg_count[r_grant] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_FEEDS; g++) begin : g_msg_count
        assign msg_count[16*g +: 16] = r_msg_count[g];
    end
`else
    assign msg_count = '0;
`endif

endmodule

// File: tb/tb_itch_feed_arb.sv
// Self-checking bench for itch_feed_arb: feed drivers plus a transaction-level
// reference model (message queues, round-robin winner, per-feed counts).
`timescale 1ns/1ps
module tb_itch_feed_arb;
    import itch_pkg::*;

    localparam int NF   = 2;
    localparam int ML   = ITCH_MSG_LEN;
    localparam int GW   = $clog2(NF);
    localparam int MAXB = 1200;

    logic              clk = 1'b0;
    logic              rst;
    logic [8*NF-1:0]   s_axis_tdata = '0;
    logic [NF-1:0]     s_axis_tvalid = '0;
    logic [NF-1:0]     s_axis_tready;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic [GW-1:0]     grant_id;
    logic              grant_active;
    logic [16*NF-1:0]  msg_count;

    always #5 clk = ~clk;

    itch_feed_arb #(.NUM_FEEDS(NF), .MSG_LEN(ML)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_id      (grant_id),
        .grant_active  (grant_active),
        .msg_count     (msg_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Feed-side byte streams and driver configuration.
    logic [7:0] stream [NF][MAXB];
    int tot [NF];
    int pos [NF];
    int vpct [NF];
    int gap_at [NF];
    int gap_len [NF];
    int gap_cnt [NF];
    int rpct;
    bit toggle_rdy;
    bit rst_arm;
    int rst_feed;
    int rst_byte;

    // Reference model: who owns the output, where in the message, counts.
    bit m_busy;
    int m_owner;
    int m_idx;
    int m_last;
    int m_gid;
    int m_pass_off;
    int m_cnt [NF];
    int winners [$];
    logic [7:0] cap0 [$];
    int last_pass_len;

    task automatic model_reset();
        m_busy     = 1'b0;
        m_owner    = 0;
        m_idx      = 0;
        m_last     = NF - 1;
        m_gid      = 0;
        m_pass_off = 0;
        for (int k = 0; k < NF; k++) begin
            m_cnt[k]   = 0;
            gap_cnt[k] = 0;
        end
    endtask

    task automatic cfg_default();
        for (int k = 0; k < NF; k++) begin
            tot[k] = 0; pos[k] = 0; vpct[k] = 100;
            gap_at[k] = 0; gap_len[k] = 0; gap_cnt[k] = 0;
        end
        rpct = 100; toggle_rdy = 1'b0; rst_arm = 1'b0;
        rst_feed = 0; rst_byte = 0;
        winners.delete();
        cap0.delete();
        last_pass_len = 0;
    endtask

    task automatic load_random(input int k, input int nmsg);
        tot[k] = nmsg * ML;
        pos[k] = 0;
        for (int i = 0; i < tot[k]; i++) stream[k][i] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [16*NF-1:0] exp_msg_count();
        logic [16*NF-1:0] r;
        r = '0;
`ifdef ITCH_ARB_STATS_EN
        for (int k = 0; k < NF; k++) r[16*k +: 16] = 16'(m_cnt[k]);
`endif
        return r;
    endfunction

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int k = 0; k < NF; k++) if (pos[k] < tot[k]) p = 1'b1;
        return p;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle();
        logic [NF-1:0] v;
        logic [NF-1:0] exp_tr;
        logic          rdy;
        bit            hs;
        bit            do_rst;
        for (int k = 0; k < NF; k++) begin
            v[k] = (pos[k] < tot[k]) && (gap_cnt[k] == 0) && ($urandom_range(99) < vpct[k]);
            s_axis_tdata[8*k +: 8] = (pos[k] < tot[k]) ? stream[k][pos[k]] : 8'h00;
        end
        if (toggle_rdy) rdy = m_busy ? m_pass_off[0] : 1'b1;
        else            rdy = ($urandom_range(99) < rpct);
        do_rst = rst_arm && m_busy && (m_owner == rst_feed) && (m_idx == rst_byte);
        if (do_rst) rdy = 1'b0;
        s_axis_tvalid = v;
        m_axis_tready = rdy;
        rst           = do_rst;

        @(negedge clk);
        exp_tr = '0;
        if (m_busy) exp_tr[m_owner] = rdy;
        check("grant_active", grant_active, m_busy);
        check("grant_id", grant_id, m_gid);
        check("m_tvalid", m_axis_tvalid, m_busy && v[m_owner]);
        check("m_tlast", m_axis_tlast, m_busy && (m_idx == ML - 1));
        check("s_tready", s_axis_tready, exp_tr);
        check("msg_count", msg_count, exp_msg_count());
        if (m_busy && v[m_owner]) check("m_tdata", m_axis_tdata, stream[m_owner][pos[m_owner]]);

        @(posedge clk);
        hs = m_busy && v[m_owner] && rdy;
        for (int k = 0; k < NF; k++) if (gap_cnt[k] > 0) gap_cnt[k]--;
        if (do_rst) begin
            // The interrupted message is abandoned; its feed moves on to the next one.
            for (int k = 0; k < NF; k++)
                if (pos[k] % ML != 0) pos[k] = (pos[k] / ML + 1) * ML;
            model_reset();
            rst_arm = 1'b0;
        end else if (m_busy) begin
            m_pass_off++;
            if (hs) begin
                if (m_owner == 0) cap0.push_back(stream[0][pos[0]]);
                pos[m_owner]++;
                if (gap_len[m_owner] > 0 && pos[m_owner] % ML == gap_at[m_owner])
                    gap_cnt[m_owner] = gap_len[m_owner];
                if (m_idx == ML - 1) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                    m_cnt[m_owner]++;
                    winners.push_back(m_owner);
                    last_pass_len = m_pass_off;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            for (int off = 1; off <= NF; off++) begin
                int c;
                c = (m_last + off) % NF;
                if (!m_busy && v[c]) begin
                    m_busy = 1'b1; m_owner = c; m_gid = c; m_pass_off = 0;
                end
            end
        end
        #1;
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        while ((m_busy || pending()) && n < budget) begin
            cycle();
            n++;
        end
        check("drained", m_busy || pending(), 1'b0);
    endtask

    logic [7:0] ao [ML] = '{8'h41, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                            8'h08, 8'h00, 8'h64, 8'h00, 8'h00, 8'h27, 8'h10};

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int qty;
        int price;
        logic [16*NF-1:0] exp_cnt;

        // Reset values.
        cfg_default();
        do_reset();
        check("rst_grant_active", grant_active, 1'b0);
        check("rst_grant_id", grant_id, '0);
        check("rst_s_tready", s_axis_tready, '0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_msg_count", msg_count, '0);

        // Single Add Order on feed 0, parser always ready.
        cfg_default();
        do_reset();
        tot[0] = ML;
        for (int i = 0; i < ML; i++) stream[0][i] = ao[i];
        run_until_done(200, n);
        check("ao_len", cap0.size(), ML);
        for (int i = 0; i < ML && i < cap0.size(); i++) check("ao_byte", cap0[i], ao[i]);
        qty   = (cap0.size() == ML) ? {cap0[9], cap0[10]} : -1;
        price = (cap0.size() == ML) ? {cap0[11], cap0[12], cap0[13], cap0[14]} : -1;
        check("ao_qty", qty, 100);
        check("ao_price", price, 10000);

        // Both feeds always valid: strict alternation, one idle cycle between.
        cfg_default();
        do_reset();
        load_random(0, 2);
        load_random(1, 2);
        run_until_done(500, n);
        check("alt_cycles", n, 4 * (ML + 1));
        check("alt_nmsg", winners.size(), 4);
        for (int i = 0; i < winners.size(); i++) check("alt_order", winners[i], i % 2);

        // Feed 1 stalls for 5 cycles mid-message while feed 0 waits.
        cfg_default();
        do_reset();
        load_random(0, 2);
        load_random(1, 1);
        gap_at[1]  = 7;
        gap_len[1] = 5;
        run_until_done(500, n);
        check("stall_cycles", n, 3 * (ML + 1) + 5);
        check("stall_nmsg", winners.size(), 3);
        if (winners.size() == 3) check("stall_second_winner", winners[1], 1);

        // Parser ready toggling 0,1 during the message: 15 bytes over 30 cycles.
        cfg_default();
        do_reset();
        load_random(0, 1);
        toggle_rdy = 1'b1;
        run_until_done(500, n);
        check("toggle_pass_len", last_pass_len, 2 * ML);
        check("toggle_nmsg", winners.size(), 1);

        // Reset at byte 8 of a feed 1 message; feed 0 wins afterwards.
        cfg_default();
        do_reset();
        load_random(0, 2);
        load_random(1, 2);
        rst_arm  = 1'b1;
        rst_feed = 1;
        rst_byte = 8;
        run_until_done(500, n);
        check("rstmid_fired", rst_arm, 1'b0);
        check("rstmid_nmsg", winners.size(), 3);
        if (winners.size() == 3) begin
            check("rstmid_first", winners[0], 0);
            check("rstmid_after", winners[1], 0);
            check("rstmid_last", winners[2], 1);
        end

        // Message statistics: 3 from feed 0, 2 from feed 1.
        cfg_default();
        do_reset();
        load_random(0, 3);
        load_random(1, 2);
        run_until_done(500, n);
        exp_cnt = '0;
`ifdef ITCH_ARB_STATS_EN
        exp_cnt = {16'd2, 16'd3};
`endif
        check("stats_count", msg_count, exp_cnt);

        // Randomised traffic, backpressure, stalls and occasional aborts.
        for (int it = 0; it < 8; it++) begin
            cfg_default();
            do_reset();
            for (int k = 0; k < NF; k++) begin
                load_random(k, $urandom_range(6, 1));
                vpct[k]    = $urandom_range(100, 30);
                gap_len[k] = $urandom_range(4, 0);
                gap_at[k]  = $urandom_range(ML - 1, 1);
            end
            rpct     = $urandom_range(100, 40);
            rst_arm  = (it % 3 == 2);
            rst_feed = $urandom_range(NF - 1, 0);
            rst_byte = $urandom_range(ML - 1, 0);
            run_until_done(6000, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
